// File: rtl/wrr_req_arbiter_if.sv
// wrr_req_arbiter_if: bundles the ingress requests, weight-table writes, dequeue-state
// updates, engine request/response and result-stream signals of wrr_req_arbiter.
//   slave  : the arbiter's view (drives in_ready, eng_req_*, eng_last_pifo_*, out_*, err_*)
//   master : the environment's view (drives requests, cfg, deq, engine response, out_ready)
interface wrr_req_arbiter_if #(
  parameter int unsigned NUM_PORTS           = 4,
  parameter int unsigned PORT_ID_WIDTH       = 2,
  parameter int unsigned CLASS_WIDTH         = 8,
  parameter int unsigned WEIGHT_WIDTH        = 16,
  parameter int unsigned PIFO_OVERFLOW_WIDTH = 1,
  parameter int unsigned PIFO_ROUND_WIDTH    = 17,
  parameter int unsigned RESULT_WIDTH        = 32
);
  logic [NUM_PORTS-1:0]             in_valid;
  logic [NUM_PORTS-1:0]             in_ready;
  logic [NUM_PORTS*CLASS_WIDTH-1:0] in_class_id;
  logic                             cfg_wr_en;
  logic [CLASS_WIDTH-1:0]           cfg_class_id;
  logic [WEIGHT_WIDTH-1:0]          cfg_weight;
  logic                             deq_valid;
  logic [PIFO_OVERFLOW_WIDTH-1:0]   deq_overflow;
  logic [PIFO_ROUND_WIDTH-1:0]      deq_round;
  logic                             eng_req_valid;
  logic [CLASS_WIDTH-1:0]           eng_req_class_id;
  logic [WEIGHT_WIDTH-1:0]          eng_req_class_weight;
  logic                             eng_last_pifo_valid;
  logic [PIFO_OVERFLOW_WIDTH-1:0]   eng_last_pifo_overflow;
  logic [PIFO_ROUND_WIDTH-1:0]      eng_last_pifo_round;
  logic                             eng_resp_valid;
  logic [RESULT_WIDTH-1:0]          eng_resp_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [PORT_ID_WIDTH-1:0]         out_port;
  logic [RESULT_WIDTH-1:0]          out_data;
  logic                             err_unexpected_resp;

  modport slave (
    input  in_valid, in_class_id, cfg_wr_en, cfg_class_id, cfg_weight,
           deq_valid, deq_overflow, deq_round, eng_resp_valid, eng_resp_data, out_ready,
    output in_ready, eng_req_valid, eng_req_class_id, eng_req_class_weight,
           eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round,
           out_valid, out_port, out_data, err_unexpected_resp
  );

  modport master (
    output in_valid, in_class_id, cfg_wr_en, cfg_class_id, cfg_weight,
           deq_valid, deq_overflow, deq_round, eng_resp_valid, eng_resp_data, out_ready,
    input  in_ready, eng_req_valid, eng_req_class_id, eng_req_class_weight,
           eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round,
           out_valid, out_port, out_data, err_unexpected_resp
  );
endinterface

// File: rtl/wrr_req_arbiter.sv
// wrr_req_arbiter: front end of the WRR rank engine. Round-robin arbitrates NUM_PORTS
// requesters onto the single engine, looks up the class weight in a writable table,
// holds the last dequeue-side PIFO state and returns tagged results through a 2-entry FIFO.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : wrr_req_arbiter_if.slave (requests, cfg, deq state, engine req/resp, results)
module wrr_req_arbiter #(
  parameter int unsigned NUM_PORTS           = 4,
  parameter int unsigned PORT_ID_WIDTH       = 2,
  parameter int unsigned CLASS_WIDTH         = 8,
  parameter int unsigned WEIGHT_WIDTH        = 16,
  parameter int unsigned PIFO_OVERFLOW_WIDTH = 1,
  parameter int unsigned PIFO_ROUND_WIDTH    = 17,
  parameter int unsigned RESULT_WIDTH        = 32
) (
  input logic              clk,
  input logic              rst,
  wrr_req_arbiter_if.slave bus
);
  localparam int unsigned TableDepth = 1 << CLASS_WIDTH;
  localparam int unsigned EntryWidth = PORT_ID_WIDTH + RESULT_WIDTH;

  logic [PORT_ID_WIDTH-1:0]       ptr_q;
  logic [PORT_ID_WIDTH-1:0]       grant;
  logic [PORT_ID_WIDTH-1:0]       idx;
  logic                           grant_found;
  logic [CLASS_WIDTH-1:0]         grant_class;
  logic                           issue;
  logic                           issue_ok;
  logic [2:0]                     credit;
  logic                           pop;
  logic                           push;
  logic                           inflight_q;
  logic [PORT_ID_WIDTH-1:0]       inflight_port_q;
  logic [WEIGHT_WIDTH-1:0]        weight_q [TableDepth];
  logic [EntryWidth-1:0]          fifo_q [2];
  logic                           rd_ptr_q;
  logic                           wr_ptr_q;
  logic [1:0]                     count_q;
  logic                           last_valid_q;
  logic [PIFO_OVERFLOW_WIDTH-1:0] last_overflow_q;
  logic [PIFO_ROUND_WIDTH-1:0]    last_round_q;
  logic                           err_q;

  // First valid requester at or after ptr, wrapping (ptr + k truncates mod NUM_PORTS).
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ptr_q + PORT_ID_WIDTH'(k);
      if (!grant_found && bus.in_valid[idx]) begin
        grant       = idx;
        grant_found = 1'b1;
      end
    end
  end

  assign grant_class = bus.in_class_id[int'(grant)*CLASS_WIDTH +: CLASS_WIDTH];
  assign pop         = (count_q != 2'd0) & bus.out_ready;
  assign push        = bus.eng_resp_valid & inflight_q;

  // Each issue reserves a FIFO slot: count + inflight never exceeds 2, so no overflow.
  assign credit   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_ok = credit < 3'd2;
  assign issue    = grant_found & issue_ok & ~rst;

  always_comb begin
    bus.in_ready             = '0;
    bus.eng_req_valid        = issue;
    bus.eng_req_class_id     = '0;
    bus.eng_req_class_weight = '0;
    if (issue) begin
      bus.in_ready[grant]      = 1'b1;
      bus.eng_req_class_id     = grant_class;
      bus.eng_req_class_weight = weight_q[grant_class];
    end
  end

  assign bus.eng_last_pifo_valid    = last_valid_q;
  assign bus.eng_last_pifo_overflow = last_overflow_q;
  assign bus.eng_last_pifo_round    = last_round_q;
  assign bus.out_valid              = count_q != 2'd0;
  assign bus.out_port               = fifo_q[rd_ptr_q][EntryWidth-1 -: PORT_ID_WIDTH];
  assign bus.out_data               = fifo_q[rd_ptr_q][RESULT_WIDTH-1:0];
  assign bus.err_unexpected_resp    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_port_q <= '0;
      last_valid_q    <= 1'b0;
      last_overflow_q <= '0;
      last_round_q    <= '0;
      err_q           <= 1'b0;
    end else begin
      if (issue) begin
        ptr_q <= grant + PORT_ID_WIDTH'(1);
      end
      inflight_q      <= issue;
      inflight_port_q <= grant;
      if (bus.deq_valid) begin
        last_valid_q    <= 1'b1;
        last_overflow_q <= bus.deq_overflow;
        last_round_q    <= bus.deq_round;
      end
      if (bus.eng_resp_valid && !inflight_q) begin
        err_q <= 1'b1;
      end
    end
  end

  // Weight 0 is stored as 1 since the engine works with weight-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TableDepth; i++) begin
        weight_q[i] <= WEIGHT_WIDTH'(1);
      end
    end else if (bus.cfg_wr_en) begin
      weight_q[bus.cfg_class_id] <= (bus.cfg_weight == '0) ? WEIGHT_WIDTH'(1) : bus.cfg_weight;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {inflight_port_q, bus.eng_resp_data};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_wrr_req_arbiter.sv
// tb_wrr_req_arbiter: directed self-checking bench for wrr_req_arbiter. A small engine
// model answers every request one cycle later with {8'hA5, class, weight}.
module tb_wrr_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eng_auto = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic       r_req;
  logic [7:0] r_cls;
  logic [15:0] r_wt;
  logic [3:0] exp_ready;

  wrr_req_arbiter_if bus ();

  wrr_req_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Engine model: response exactly one cycle after each request.
  always @(posedge clk) begin
    r_req = bus.eng_req_valid;
    r_cls = bus.eng_req_class_id;
    r_wt  = bus.eng_req_class_weight;
    #1;
    if (eng_auto) begin
      bus.eng_resp_valid = r_req;
      bus.eng_resp_data  = {8'hA5, r_cls, r_wt};
    end
  end

  // A push into a full FIFO without a simultaneous pop must never happen.
  always @(negedge clk) begin
    if (!rst && dut.push && dut.count_q == 2'd2 && !(bus.out_valid && bus.out_ready)) begin
      errors++;
      $display("FAIL fifo_overflow: push with count %0d, required count < 2", dut.count_q);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] res(input logic [7:0] c, input logic [15:0] w);
    return {8'hA5, c, w};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    #1;
    checks++; if (bus.in_ready !== 4'h0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    rst = 1'b0;
    tick;
    #1;
    checks++; if (bus.eng_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus.eng_req_valid); end
    checks++; if (bus.eng_req_class_id !== 8'd0) begin errors++; $display("FAIL rst_class: got %0d want 0", bus.eng_req_class_id); end
    checks++; if (bus.eng_req_class_weight !== 16'd0) begin errors++; $display("FAIL rst_weight: got %0d want 0", bus.eng_req_class_weight); end
    checks++; if (bus.eng_last_pifo_valid !== 1'b0) begin errors++; $display("FAIL rst_pifo_valid: got %b want 0", bus.eng_last_pifo_valid); end
    checks++; if (bus.eng_last_pifo_round !== 17'd0) begin errors++; $display("FAIL rst_pifo_round: got %0d want 0", bus.eng_last_pifo_round); end
    checks++; if (bus.eng_last_pifo_overflow !== 1'b0) begin errors++; $display("FAIL rst_pifo_ovf: got %b want 0", bus.eng_last_pifo_overflow); end
    checks++; if (bus.out_port !== 2'd0) begin errors++; $display("FAIL rst_out_port: got %0d want 0", bus.out_port); end
    checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.err_unexpected_resp !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err_unexpected_resp); end
  endtask

  task automatic test_round_robin;
    bus.out_ready = 1'b1;
    for (int p = 0; p < 4; p++) bus.in_class_id[p*8 +: 8] = 8'(10 + p);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      exp_ready = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rr_ready c=%0d: got %b want %b", c, bus.in_ready, exp_ready); end
      if (c < 8) begin
        checks++; if (bus.eng_req_class_id !== 8'(10 + c % 4)) begin errors++; $display("FAIL rr_class c=%0d: got %0d want %0d", c, bus.eng_req_class_id, 10 + c % 4); end
      end
      checks++; if (bus.out_valid !== (c >= 2)) begin errors++; $display("FAIL rr_out_valid c=%0d: got %b want %b", c, bus.out_valid, c >= 2); end
      if (c >= 2) begin
        checks++; if (bus.out_port !== 2'((c - 2) % 4)) begin errors++; $display("FAIL rr_out_port c=%0d: got %0d want %0d", c, bus.out_port, (c - 2) % 4); end
        checks++; if (bus.out_data !== res(8'(10 + (c - 2) % 4), 16'd1)) begin errors++; $display("FAIL rr_out_data c=%0d: got %h want %h", c, bus.out_data, res(8'(10 + (c - 2) % 4), 16'd1)); end
      end
      tick;
    end
  endtask

  task automatic test_weight;
    bus.cfg_wr_en = 1'b1; bus.cfg_class_id = 8'd7; bus.cfg_weight = 16'd5;
    tick;
    bus.cfg_wr_en = 1'b0;
    bus.in_class_id[2*8 +: 8] = 8'd7;
    bus.in_valid = 4'b0100;
    #1;
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL wt_ready: got %b want 0100", bus.in_ready); end
    checks++; if (bus.eng_req_class_id !== 8'd7) begin errors++; $display("FAIL wt_class: got %0d want 7", bus.eng_req_class_id); end
    checks++; if (bus.eng_req_class_weight !== 16'd5) begin errors++; $display("FAIL wt_five: got %0d want 5", bus.eng_req_class_weight); end
    tick;
    bus.in_valid = 4'h0;
    bus.cfg_wr_en = 1'b1; bus.cfg_weight = 16'd0;
    tick;
    bus.cfg_wr_en = 1'b0;
    bus.in_valid = 4'b0100;
    #1;
    checks++; if (bus.eng_req_class_weight !== 16'd1) begin errors++; $display("FAIL wt_zero_as_one: got %0d want 1", bus.eng_req_class_weight); end
    tick;
    bus.in_valid = 4'h0;
    bus.cfg_wr_en = 1'b1; bus.cfg_weight = 16'd5;
    tick;
    bus.cfg_weight = 16'd9;
    bus.in_valid = 4'b0100;
    #1;
    checks++; if (bus.eng_req_class_weight !== 16'd5) begin errors++; $display("FAIL wt_same_cycle_old: got %0d want 5", bus.eng_req_class_weight); end
    tick;
    bus.cfg_wr_en = 1'b0;
    #1;
    checks++; if (bus.eng_req_class_weight !== 16'd9) begin errors++; $display("FAIL wt_new: got %0d want 9", bus.eng_req_class_weight); end
    tick;
    bus.in_valid = 4'h0;
    repeat (3) tick;
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    bus.in_class_id[1*8 +: 8] = 8'd20;
    bus.in_valid = 4'b0010;
    #1;
    checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_issue0: got %b want 0010", bus.in_ready); end
    tick;
    bus.in_class_id[1*8 +: 8] = 8'd21;
    #1;
    checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_issue1: got %b want 0010", bus.in_ready); end
    tick;
    bus.in_class_id[1*8 +: 8] = 8'd22;
    #1;
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall0: got %b want 0000", bus.in_ready); end
    checks++; if (bus.eng_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stall: got %b want 0", bus.eng_req_valid); end
    tick;
    #1;
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall1: got %b want 0000", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_port !== 2'd1) begin errors++; $display("FAIL bp_out_port: got %0d want 1", bus.out_port); end
    tick;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.out_data !== res(8'd20, 16'd1)) begin errors++; $display("FAIL bp_pop0: got %h want %h", bus.out_data, res(8'd20, 16'd1)); end
    checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_resume: got %b want 0010", bus.in_ready); end
    tick;
    bus.in_valid = 4'h0;
    #1;
    checks++; if (bus.out_data !== res(8'd21, 16'd1)) begin errors++; $display("FAIL bp_pop1: got %h want %h", bus.out_data, res(8'd21, 16'd1)); end
    tick;
    #1;
    checks++; if (bus.out_data !== res(8'd22, 16'd1)) begin errors++; $display("FAIL bp_pop2: got %h want %h", bus.out_data, res(8'd22, 16'd1)); end
    tick;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
    tick;
  endtask

  task automatic test_deq;
    bus.deq_valid = 1'b1; bus.deq_overflow = 1'b1; bus.deq_round = 17'd100;
    bus.in_class_id[0 +: 8] = 8'd3;
    bus.in_valid = 4'b0001;
    #1;
    checks++; if (bus.eng_req_valid !== 1'b1) begin errors++; $display("FAIL deq_issue: got %b want 1", bus.eng_req_valid); end
    checks++; if (bus.eng_last_pifo_valid !== 1'b0) begin errors++; $display("FAIL deq_old_valid: got %b want 0", bus.eng_last_pifo_valid); end
    checks++; if (bus.eng_last_pifo_round !== 17'd0) begin errors++; $display("FAIL deq_old_round: got %0d want 0", bus.eng_last_pifo_round); end
    tick;
    bus.deq_valid = 1'b0; bus.deq_overflow = 1'b0; bus.deq_round = 17'd0;
    bus.in_valid = 4'h0;
    #1;
    checks++; if (bus.eng_last_pifo_valid !== 1'b1) begin errors++; $display("FAIL deq_valid: got %b want 1", bus.eng_last_pifo_valid); end
    checks++; if (bus.eng_last_pifo_overflow !== 1'b1) begin errors++; $display("FAIL deq_ovf: got %b want 1", bus.eng_last_pifo_overflow); end
    checks++; if (bus.eng_last_pifo_round !== 17'd100) begin errors++; $display("FAIL deq_round: got %0d want 100", bus.eng_last_pifo_round); end
    repeat (2) tick;
    #1;
    checks++; if (bus.eng_last_pifo_round !== 17'd100) begin errors++; $display("FAIL deq_hold: got %0d want 100", bus.eng_last_pifo_round); end
    bus.deq_valid = 1'b1; bus.deq_round = 17'd200;
    tick;
    bus.deq_valid = 1'b0;
    #1;
    checks++; if (bus.eng_last_pifo_round !== 17'd200) begin errors++; $display("FAIL deq_round2: got %0d want 200", bus.eng_last_pifo_round); end
    checks++; if (bus.eng_last_pifo_overflow !== 1'b0) begin errors++; $display("FAIL deq_ovf2: got %b want 0", bus.eng_last_pifo_overflow); end
    checks++; if (bus.eng_last_pifo_valid !== 1'b1) begin errors++; $display("FAIL deq_valid2: got %b want 1", bus.eng_last_pifo_valid); end
    tick;
  endtask

  task automatic test_unexpected;
    repeat (2) tick;
    eng_auto = 1'b0;
    bus.eng_resp_valid = 1'b1;
    bus.eng_resp_data  = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.err_unexpected_resp !== 1'b0) begin errors++; $display("FAIL unexp_before: got %b want 0", bus.err_unexpected_resp); end
    tick;
    bus.eng_resp_valid = 1'b0;
    #1;
    checks++; if (bus.err_unexpected_resp !== 1'b1) begin errors++; $display("FAIL unexp_set: got %b want 1", bus.err_unexpected_resp); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL unexp_no_push: got %b want 0", bus.out_valid); end
    repeat (2) tick;
    #1;
    checks++; if (bus.err_unexpected_resp !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %b want 1", bus.err_unexpected_resp); end
    eng_auto = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    bus.in_class_id[0 +: 8] = 8'd4;
    bus.in_valid = 4'b0001;
    repeat (3) tick;
    bus.in_valid = 4'h0;
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rm_full: got %b want 1", bus.out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL rm_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.err_unexpected_resp !== 1'b0) begin errors++; $display("FAIL rm_err: got %b want 0", bus.err_unexpected_resp); end
    checks++; if (bus.eng_last_pifo_valid !== 1'b0) begin errors++; $display("FAIL rm_pifo: got %b want 0", bus.eng_last_pifo_valid); end
    tick;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    for (int p = 0; p < 4; p++) bus.in_class_id[p*8 +: 8] = 8'd7;
    bus.in_valid = 4'hF;
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr: got %b want 0001", bus.in_ready); end
    checks++; if (bus.eng_req_class_weight !== 16'd1) begin errors++; $display("FAIL rm_table: got %0d want 1", bus.eng_req_class_weight); end
    tick;
    bus.in_valid = 4'h0;
    repeat (3) tick;
  endtask

  initial begin
    bus.in_valid = '0; bus.in_class_id = '0;
    bus.cfg_wr_en = 1'b0; bus.cfg_class_id = '0; bus.cfg_weight = '0;
    bus.deq_valid = 1'b0; bus.deq_overflow = '0; bus.deq_round = '0;
    bus.eng_resp_valid = 1'b0; bus.eng_resp_data = '0;
    bus.out_ready = 1'b0;
    test_reset;
    test_round_robin;
    test_weight;
    test_backpressure;
    test_deq;
    test_unexpected;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
